// File: rtl/codificador_botoes.sv
// codificador_botoes: button encoder for the Genius game.
// Synchronizes and debounces four raw push-buttons. Each accepted press
// produces a registered one-hot code and a one-cycle jogada_feita pulse.
// Bit 3 = verde, bit 2 = amarelo, bit 1 = azul, bit 0 = vermelho.
//
// Optional feature, macro BOTOES_PRIORIDADE_EN:
//   defined   - a multi-button press is resolved by fixed priority
//               (bit 0 highest) and erro_multiplo is never asserted.
//   undefined - a multi-button press pulses erro_multiplo and codigo is kept.
//
// state       | meaning
// OCIOSO      | no debounced button held, waiting for a press
// PRESSIONADO | a press was handled, waiting for all buttons released
module codificador_botoes #(
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int LARGURA_CONT    = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] botoes,
  output logic [3:0] codigo,
  output logic       jogada_feita,
  output logic       erro_multiplo,
  output logic       ocupado
);

  typedef enum logic {
    OCIOSO      = 1'b0,
    PRESSIONADO = 1'b1
  } estado_t;

  localparam logic [LARGURA_CONT-1:0] CONT_MAX = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);

  logic [3:0]              sync1_q, sync2_q, sync_prev_q;
  logic [LARGURA_CONT-1:0] cont_q, cont_d;
  logic [3:0]              deb_q, deb_d;
  estado_t                 estado_q, estado_d;
  logic [3:0]              codigo_q, codigo_d;
  logic                    jogada_q, jogada_d;
  logic                    erro_q, erro_d;
  logic                    ocupado_q, ocupado_d;
  logic                    unico;
`ifdef BOTOES_PRIORIDADE_EN
  logic [3:0]              prioridade;
`endif

  // Debounce: count cycles of unchanged sync value; accept it once saturated.
  // The load also requires sync to still match its previous value so that a
  // change arriving while the counter sits at its limit is not accepted.
  always_comb begin
    cont_d = cont_q;
    deb_d  = deb_q;
    if (sync2_q != sync_prev_q) begin
      cont_d = '0;
    end else begin
      if (cont_q < CONT_MAX) cont_d = cont_q + 1'b1;
      if (cont_q == CONT_MAX) deb_d = sync2_q;
    end
  end

  // Press classification on the value being loaded into the debounced vector,
  // so the outputs react in the same edge the press is accepted.
  assign unico = (deb_d != 4'd0) && ((deb_d & (deb_d - 4'd1)) == 4'd0);
`ifdef BOTOES_PRIORIDADE_EN
  // Isolates the lowest set bit: vermelho wins over azul, amarelo, verde.
  assign prioridade = deb_d & (~deb_d + 4'd1);
`endif

  // FSM next state and next registered outputs.
  always_comb begin
    estado_d = estado_q;
    codigo_d = codigo_q;
    jogada_d = 1'b0;
    erro_d   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (deb_d != 4'd0) begin
          estado_d = PRESSIONADO;
          if (unico) begin
            codigo_d = deb_d;
            jogada_d = 1'b1;
          end else begin
`ifdef BOTOES_PRIORIDADE_EN
            codigo_d = prioridade;
            jogada_d = 1'b1;
`else
            erro_d   = 1'b1;
`endif
          end
        end
      end
      PRESSIONADO: begin
        if (deb_d == 4'd0) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    ocupado_d = (estado_d == PRESSIONADO);
  end

  // All state: synchronizer, debounce, FSM and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q     <= 4'd0;
      sync2_q     <= 4'd0;
      sync_prev_q <= 4'd0;
      cont_q      <= '0;
      deb_q       <= 4'd0;
      estado_q    <= OCIOSO;
      codigo_q    <= 4'd0;
      jogada_q    <= 1'b0;
      erro_q      <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      sync1_q     <= botoes;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      cont_q      <= cont_d;
      deb_q       <= deb_d;
      estado_q    <= estado_d;
      codigo_q    <= codigo_d;
      jogada_q    <= jogada_d;
      erro_q      <= erro_d;
      ocupado_q   <= ocupado_d;
    end
  end

  assign codigo        = codigo_q;
  assign jogada_feita  = jogada_q;
  assign erro_multiplo = erro_q;
  assign ocupado       = ocupado_q;

endmodule

// File: tb/tb_codificador_botoes.sv
// Testbench for codificador_botoes with DEBOUNCE_CICLOS=4.
// A reference model predicts pulses into a queue; a monitor pops and
// compares them when the DUT pulses, and checks codigo/ocupado every cycle.
module tb_codificador_botoes;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] botoes = 4'd0;
  logic [3:0] codigo;
  logic       jogada_feita, erro_multiplo, ocupado;

  always #5 clock = ~clock;

  codificador_botoes #(.DEBOUNCE_CICLOS(D), .LARGURA_CONT(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .botoes(botoes),
    .codigo(codigo),
    .jogada_feita(jogada_feita),
    .erro_multiplo(erro_multiplo),
    .ocupado(ocupado)
  );

  typedef struct {
    int         cyc;
    bit         err;
    logic [3:0] cod;
  } ev_t;

  ev_t esperado[$];
  int  testes = 0;
  int  falhas = 0;
  int  cyc = 0;

  // Reference model: sync value is the raw input two edges late; a value is
  // accepted after it has been seen D+1 consecutive clocks.
  logic [3:0] m_est1 = 4'd0, m_runv = 4'd0, m_deb = 4'd0, m_cod = 4'd0;
  int         m_runl = 1;
  bit         m_busy = 1'b0;

  always @(posedge clock) begin : modelo
    ev_t        ev;
    logic [3:0] s_new;
    int         sel;
    cyc++;
    if (!reset_n) begin
      m_est1 = 4'd0; m_runv = 4'd0; m_runl = 1;
      m_deb = 4'd0; m_cod = 4'd0; m_busy = 1'b0;
    end else begin
      if (m_runl >= D + 1) m_deb = m_runv;
      if (!m_busy) begin
        if (m_deb != 4'd0) begin
          m_busy = 1'b1;
          ev.cyc = cyc;
          if ($countones(m_deb) == 1) begin
            m_cod  = m_deb;
            ev.err = 1'b0;
          end else begin
`ifdef BOTOES_PRIORIDADE_EN
            sel = 0;
            for (int i = 3; i >= 0; i--) if (m_deb[i]) sel = i;
            m_cod  = 4'b0001 << sel;
            ev.err = 1'b0;
`else
            sel    = 0;
            ev.err = 1'b1;
`endif
          end
          ev.cod = m_cod;
          esperado.push_back(ev);
        end
      end else if (m_deb == 4'd0) begin
        m_busy = 1'b0;
      end
      s_new  = m_est1;
      m_est1 = botoes;
      if (s_new == m_runv) m_runl++;
      else begin
        m_runv = s_new;
        m_runl = 1;
      end
    end
  end

  // Monitor: compare DUT outputs against the model away from the active edge.
  always @(negedge clock) begin : monitor
    ev_t ev;
    while (esperado.size() > 0 && esperado[0].cyc < cyc) begin
      ev = esperado.pop_front();
      testes++; falhas++;
      $display("FAIL pulso_ausente: cycle %0d expected err=%0d codigo=%b, got no pulse", ev.cyc, ev.err, ev.cod);
    end
    testes++;
    if (ocupado !== m_busy) begin
      falhas++;
      $display("FAIL ocupado: cycle %0d got %b expected %b", cyc, ocupado, m_busy);
    end
    testes++;
    if (codigo !== m_cod) begin
      falhas++;
      $display("FAIL codigo: cycle %0d got %b expected %b", cyc, codigo, m_cod);
    end
    if (jogada_feita === 1'b1 && erro_multiplo === 1'b1) begin
      testes++; falhas++;
      $display("FAIL pulsos_simultaneos: cycle %0d got both high expected at most one", cyc);
    end
    if (jogada_feita === 1'b1 || erro_multiplo === 1'b1) begin
      testes++;
      if (esperado.size() == 0) begin
        falhas++;
        $display("FAIL pulso_inesperado: cycle %0d got jogada=%b erro=%b expected none", cyc, jogada_feita, erro_multiplo);
      end else begin
        ev = esperado.pop_front();
        if (ev.cyc != cyc || erro_multiplo !== ev.err || codigo !== ev.cod) begin
          falhas++;
          $display("FAIL pulso: got cycle %0d erro=%b codigo=%b expected cycle %0d erro=%0d codigo=%b",
                   cyc, erro_multiplo, codigo, ev.cyc, ev.err, ev.cod);
        end
      end
    end
  end

  task automatic segura(input logic [3:0] v, input int n);
    botoes = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic pulso_reset(input int n);
    reset_n = 1'b0;
    repeat (n) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int         r;
    logic [3:0] v;
    reset_n = 1'b0;
    botoes  = 4'd0;
    repeat (10) @(negedge clock);
    reset_n = 1'b1;
    segura(4'b0000, 20);
    segura(4'b1000, 20);
    segura(4'b0000, 20);
    for (int i = 0; i < 8; i++) begin
      segura(4'b0010, 2);
      segura(4'b0000, 2);
    end
    segura(4'b0000, 20);
    segura(4'b0101, 20);
    segura(4'b0000, 20);
    segura(4'b0100, 10);
    segura(4'b0110, 15);
    segura(4'b0000, 20);
    segura(4'b0001, 20);
    segura(4'b0000, 20);
    segura(4'b0001, 12);
    pulso_reset(1);
    segura(4'b0001, 20);
    segura(4'b0000, 20);
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) v = 4'd0;
      else if (r <= 6) v = 4'b0001 << $urandom_range(0, 3);
      else v = 4'($urandom_range(0, 15));
      if (r == 9) pulso_reset($urandom_range(1, 3));
      else segura(v, $urandom_range(1, 14));
    end
    segura(4'b0000, 30);
    testes++;
    if (esperado.size() != 0) begin
      falhas++;
      $display("FAIL fila_final: got %0d pending pulses expected 0", esperado.size());
    end
    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
